sa_autosa_ssa_syncnd_filt: RTL and testbench

// - Parametrised successor of the single-bit 3-flop synchroniser: WIDTH independent async

---
 rtl/sa_autosa_sync_pkg.sv | 14 +
 rtl/sa_autosa_sync_filt_ch.sv | 69 ++++++
 rtl/sa_autosa_ssa_syncnd_filt.sv | 51 +++++
 tb/tb_sa_autosa_ssa_syncnd_filt.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sa_autosa_sync_pkg.sv
// Shared constants and helpers for the AUTOSA level-synchroniser family.
// Combinational only; no latency or flow control.
package sa_autosa_sync_pkg;

  localparam int SYNC_MIN_STAGES = 2;

  // Counter width able to hold 0..filt_cyc, never narrower than one bit.
  function automatic int sync_cnt_w(input int filt_cyc);
    int w;
    w = $clog2(filt_cyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sa_autosa_sync_filt_ch.sv
// One channel: STAGES-deep synchroniser chain, FILT_CYC stability filter, edge pulses.
// Latency STAGES + max(FILT_CYC,1) edges from a clean input step; no backpressure.
module sa_autosa_sync_filt_ch
  import sa_autosa_sync_pkg::*;
#(
  parameter int   STAGES   = 3,
  parameter int   FILT_CYC = 4,
  parameter logic RST_BIT  = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall,
  output logic o_upd
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_chain;
  logic r_sync;
  logic r_rise;
  logic r_fall;
  logic w_q;
  logic w_diff;
  logic w_upd;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_chain <= {STAGES{RST_BIT}};
    else       r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign w_q    = r_chain[STAGES-1];
  assign w_diff = w_q ^ r_sync;

  if (FILT_CYC == 0) begin : g_bypass
    assign w_upd = w_diff;
  end else begin : g_filt
    localparam int CW = sync_cnt_w(FILT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYC - 1);
    logic [CW-1:0] r_cnt;

    assign w_upd = w_diff && (r_cnt == CNT_LAST);

    // Any cycle agreeing with the current output discards the partial count.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                r_cnt <= '0;
      else if (!w_diff || w_upd) r_cnt <= '0;
      else                      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= RST_BIT;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      if (w_upd) r_sync <= w_q;
      r_rise <= w_upd & w_q;
      r_fall <= w_upd & ~w_q;
    end
  end

  assign o_q    = r_sync;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
  assign o_upd  = w_upd;

endmodule

// File: rtl/sa_autosa_ssa_syncnd_filt.sv
// WIDTH independent async levels synchronised, glitch-filtered, with rise/fall/any-change pulses.
// Latency STAGES + max(FILT_CYC,1) edges; channels are not coherent with each other; no backpressure.
module sa_autosa_ssa_syncnd_filt
  import sa_autosa_sync_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               STAGES   = 3,
  parameter int               FILT_CYC = 4,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] sync_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             chg_o
);

  if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
    $error("sa_autosa_ssa_syncnd_filt: STAGES must be at least %0d", SYNC_MIN_STAGES);
  end

  logic [WIDTH-1:0] w_upd;
  logic             r_chg;

  for (genvar n = 0; n < WIDTH; n++) begin : g_ch
    sa_autosa_sync_filt_ch #(
      .STAGES  (STAGES),
      .FILT_CYC(FILT_CYC),
      .RST_BIT (RST_VAL[n])
    ) u_ch (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (sync_i[n]),
      .o_q   (sync_o[n]),
      .o_rise(rise_o[n]),
      .o_fall(fall_o[n]),
      .o_upd (w_upd[n])
    );
  end

  // Registered on the same edge as the per-channel pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_chg <= 1'b0;
    else       r_chg <= |w_upd;
  end

  assign chg_o = r_chg;

endmodule

// File: tb/tb_sa_autosa_ssa_syncnd_filt.sv
// Bench for the filtered level synchroniser: reset, vector table, bypass, mid-op reset, random vs model.
module tb_sa_autosa_ssa_syncnd_filt;

  localparam int MS = 3;
  localparam int MW = 4;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] din   = 8'hFF;
  logic [7:0] sync_o, rise_o, fall_o;
  logic       chg_o;
  logic [7:0] byp_i = 8'h00;
  logic [7:0] byp_sync, byp_rise, byp_fall;
  logic       byp_chg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  sa_autosa_ssa_syncnd_filt dut (
    .i_clk(i_clk), .i_rst(i_rst), .sync_i(din),
    .sync_o(sync_o), .rise_o(rise_o), .fall_o(fall_o), .chg_o(chg_o)
  );

  sa_autosa_ssa_syncnd_filt #(.WIDTH(8), .STAGES(2), .FILT_CYC(0), .RST_VAL(8'h00)) dut_byp (
    .i_clk(i_clk), .i_rst(i_rst), .sync_i(byp_i),
    .sync_o(byp_sync), .rise_o(byp_rise), .fall_o(byp_fall), .chg_o(byp_chg)
  );

  typedef struct {
    logic [7:0]  din;
    int unsigned n;
    logic [7:0]  sync;
    logic [7:0]  rise;
    logic [7:0]  fall;
    logic        chg;
  } vec_t;

  vec_t vt[16];

  // Reference model: sample history, newest first; the filter at an edge sees the sample
  // taken MS edges earlier and flips a bit once MW consecutive seen values disagree with it.
  logic [7:0] hist[$];
  logic [7:0] m_out, m_rise, m_fall;
  logic       m_chg;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < MS + MW; i++) hist.push_front(8'h00);
    m_out = 8'h00; m_rise = 8'h00; m_fall = 8'h00; m_chg = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] smp);
    logic [7:0] upd;
    hist.push_front(smp);
    while (hist.size() > MS + MW) void'(hist.pop_back());
    upd = 8'hFF;
    for (int j = 0; j < MW; j++) upd &= hist[MS + j] ^ m_out;
    m_rise = upd & ~m_out;
    m_fall = upd & m_out;
    m_chg  = |upd;
    m_out  = m_out ^ upd;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] s, input logic [7:0] r,
                         input logic [7:0] f, input logic c);
    chk({tag, ".sync_o"}, sync_o, s);
    chk({tag, ".rise_o"}, rise_o, r);
    chk({tag, ".fall_o"}, fall_o, f);
    chk({tag, ".chg_o"}, {7'd0, chg_o}, {7'd0, c});
  endtask

  task automatic chk_byp(input string tag, input logic [7:0] s, input logic [7:0] r,
                         input logic [7:0] f, input logic c);
    chk({tag, ".sync_o"}, byp_sync, s);
    chk({tag, ".rise_o"}, byp_rise, r);
    chk({tag, ".fall_o"}, byp_fall, f);
    chk({tag, ".chg_o"}, {7'd0, byp_chg}, {7'd0, c});
  endtask

  initial begin
    logic [7:0] prev;

    vt[0]  = '{8'h00, 7, 8'h00, 8'h00, 8'hFF, 1'b1};
    vt[1]  = '{8'h00, 1, 8'h00, 8'h00, 8'h00, 1'b0};
    vt[2]  = '{8'h04, 7, 8'h04, 8'h04, 8'h00, 1'b1};
    vt[3]  = '{8'h04, 1, 8'h04, 8'h00, 8'h00, 1'b0};
    vt[4]  = '{8'h00, 7, 8'h00, 8'h00, 8'h04, 1'b1};
    vt[5]  = '{8'h00, 1, 8'h00, 8'h00, 8'h00, 1'b0};
    vt[6]  = '{8'h20, 3, 8'h00, 8'h00, 8'h00, 1'b0};
    vt[7]  = '{8'h00, 8, 8'h00, 8'h00, 8'h00, 1'b0};
    vt[8]  = '{8'h20, 4, 8'h00, 8'h00, 8'h00, 1'b0};
    vt[9]  = '{8'h00, 3, 8'h20, 8'h20, 8'h00, 1'b1};
    vt[10] = '{8'h00, 4, 8'h00, 8'h00, 8'h20, 1'b1};
    vt[11] = '{8'h00, 1, 8'h00, 8'h00, 8'h00, 1'b0};
    vt[12] = '{8'hC3, 7, 8'hC3, 8'hC3, 8'h00, 1'b1};
    vt[13] = '{8'h81, 7, 8'h81, 8'h00, 8'h42, 1'b1};
    vt[14] = '{8'h00, 7, 8'h00, 8'h00, 8'h81, 1'b1};
    vt[15] = '{8'h00, 1, 8'h00, 8'h00, 8'h00, 1'b0};

    // Reset with all inputs high: nothing may appear until 7 edges after release.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all("rst_hold", 8'h00, 8'h00, 8'h00, 1'b0);
    end
    i_rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 7)       chk_all("rst_exit", 8'h00, 8'h00, 8'h00, 1'b0);
      else if (k == 7) chk_all("rst_exit7", 8'hFF, 8'hFF, 8'h00, 1'b1);
      else             chk_all("rst_exit8", 8'hFF, 8'h00, 8'h00, 1'b0);
    end

    // Vector table: intermediate edges must hold the previous output with no pulses.
    prev = 8'hFF;
    for (int v = 0; v < 16; v++) begin
      din = vt[v].din;
      for (int e = 1; e <= int'(vt[v].n); e++) begin
        tick();
        if (e == int'(vt[v].n))
          chk_all($sformatf("vec%0d", v), vt[v].sync, vt[v].rise, vt[v].fall, vt[v].chg);
        else
          chk_all($sformatf("vec%0d_mid", v), prev, 8'h00, 8'h00, 1'b0);
      end
      prev = vt[v].sync;
    end

    // Bypass instance: a one-cycle glitch passes straight through after 3 edges.
    byp_i = 8'h01;
    tick();
    byp_i = 8'h00;
    tick(); chk_byp("byp_e2", 8'h00, 8'h00, 8'h00, 1'b0);
    tick(); chk_byp("byp_e3", 8'h01, 8'h01, 8'h00, 1'b1);
    tick(); chk_byp("byp_e4", 8'h00, 8'h00, 8'h01, 1'b1);
    tick(); chk_byp("byp_e5", 8'h00, 8'h00, 8'h00, 1'b0);

    // Mid-operation reset with the channel 1 counter part-way: full latency restarts.
    din = 8'h02;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_all("midrst_pre", 8'h00, 8'h00, 8'h00, 1'b0);
    end
    i_rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk_all("midrst_in", 8'h00, 8'h00, 8'h00, 1'b0);
    end
    i_rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k < 7) chk_all("midrst_post", 8'h00, 8'h00, 8'h00, 1'b0);
      else       chk_all("midrst_7", 8'h02, 8'h02, 8'h00, 1'b1);
    end

    // Random jittered stimulus against the model.
    i_rst = 1'b1;
    din   = 8'($urandom);
    tick();
    tick();
    i_rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      model_step(din);
      chk_all("rand", m_out, m_rise, m_fall, m_chg);
      #($urandom_range(1, 7));
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 5) == 0) din[b] = ~din[b];
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
